// File: rtl/multi_single_shot_pkg.sv
// Shared constants for the multi-channel single-shot pulse generator.
package multi_single_shot_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_RISE   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_FALL   = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BOTH   = 2'd2;
  localparam logic [MODE_W-1:0] MODE_REPEAT = 2'd3;

endpackage

// File: rtl/single_shot_channel.sv
// One channel: two-flop synchroniser, debounce counter, debounced level,
// hold-to-repeat counter and the registered one-cycle pulse.
module single_shot_channel
  import multi_single_shot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  input  logic              mode_chg,
  input  logic              enable,
  output logic              level,
  output logic              q,
  output logic              pulse_d
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam bit REP_ON = (REPEAT_DELAY > 0);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rep;
  logic          toggle;
  logic          rise;
  logic          fall;
  logic          edge_hit;
  logic          rep_hit;
  logic          rep_load;
  logic          rep_clear;

  // Toggle/pulse decision for this edge; rep counts down to 1, which marks a repeat pulse.
  always_comb begin
    toggle    = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    rise      = toggle && !level;
    fall      = toggle && level;
    edge_hit  = (rise && (mode != MODE_FALL)) ||
                (fall && ((mode == MODE_FALL) || (mode == MODE_BOTH)));
    rep_clear = !enable || mode_chg || fall;
    rep_hit   = (rep == RW'(1)) && !rep_clear;
    rep_load  = REP_ON && rise && (mode == MODE_REPEAT) && !rep_clear;
    pulse_d   = enable && (edge_hit || rep_hit);
  end

  // Synchroniser, debounce, level, repeat counter and pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rep   <= '0;
      q     <= 1'b0;
    end else begin
      sync1 <= start;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (toggle) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (rep_clear) begin
        rep <= '0;
      end else if (rep_load) begin
        rep <= RW'(REPEAT_DELAY);
      end else if (rep == RW'(1)) begin
        rep <= RW'(REPEAT_PERIOD);
      end else if (rep != '0) begin
        rep <= rep - RW'(1);
      end
      q <= pulse_d;
    end
  end

endmodule

// File: rtl/multi_single_shot.sv
// Multi-channel single-shot pulse generator: CHANNELS independent
// debounced edge detectors sharing mode/enable, plus a registered OR of q.
module multi_single_shot
  import multi_single_shot_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] start,
  input  logic [MODE_W-1:0]   mode,
  input  logic                enable,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] level,
  output logic                any_q
);

  logic [MODE_W-1:0]   mode_q;
  logic                mode_chg;
  logic [CHANNELS-1:0] pulse_d;

  // A mode different from last edge's clears every repeat counter.
  always_comb begin
    mode_chg = (mode != mode_q);
  end

  // Previous mode, and any_q registered on the same edge as the q bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_RISE;
      any_q  <= 1'b0;
    end else begin
      mode_q <= mode;
      any_q  <= |pulse_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    single_shot_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .start   (start[i]),
      .mode    (mode),
      .mode_chg(mode_chg),
      .enable  (enable),
      .level   (level[i]),
      .q       (q[i]),
      .pulse_d (pulse_d[i])
    );
  end

endmodule
